// File: rtl/lcd_pkg.sv
// Shared types and helpers for the LCD sequencer.
//   state_t      : sequencer states (PWR_WAIT, ISSUE, WAIT, GAP, READY)
//   init_entry_t : one init transfer {rs, nibble, delay in microseconds}
//   INIT_LEN     : number of transfers in the power-on init sequence
//   us_to_cycles : microseconds -> clock cycles, evaluated at elaboration
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        ISSUE,
        WAIT,
        GAP,
        READY
    } state_t;

    typedef struct packed {
        logic        rs;
        logic [3:0]  nibble;
        logic [12:0] delay_us;
    } init_entry_t;

    localparam int unsigned     INIT_LEN  = 14;
    // Largest value representable on the 21-bit commandDelay bus.
    localparam longint unsigned DELAY_MAX = 64'd2097151;

    // Wide arithmetic so an oversized product can be detected before truncation.
    function automatic longint unsigned us_to_cycles(input longint unsigned us,
                                                     input longint unsigned freq);
        return us * (freq / 64'd1000000);
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Host byte-write channel into the LCD sequencer.
//   wr_valid : host has a byte to send
//   wr_ready : sequencer can accept a byte
//   wr_rs    : 0 = instruction, 1 = character data
//   wr_data  : byte to send
// Handshake: a byte transfers on a cycle where wr_valid and wr_ready are both
// high. wr_ready never depends on wr_valid; a valid that is withdrawn before
// wr_ready rises is simply lost (nothing is queued).
// Modports: master = host side, slave = sequencer side.
interface lcd_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_rs;
    logic [7:0] wr_data;

    modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_init_rom.sv
// Combinational lookup of the HD44780 4-bit initialisation sequence.
//   i_idx   : transfer index 0..INIT_LEN-1
//   o_entry : {rs, nibble, delay_us} for that transfer
// The first four entries are the single-nibble wake-up/function-set writes;
// the rest are hi/lo nibble pairs of 0x28, 0x08, 0x01, 0x06, 0x0C.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter int unsigned CMD_US   = 40,
    parameter int unsigned CLEAR_US = 1640,
    parameter int unsigned NIB_US   = 1
) (
    input  logic [3:0]  i_idx,
    output init_entry_t o_entry
);
    localparam logic [12:0] D_CMD   = 13'(CMD_US);
    localparam logic [12:0] D_CLEAR = 13'(CLEAR_US);
    localparam logic [12:0] D_NIB   = 13'(NIB_US);

    always_comb begin
        o_entry.rs       = 1'b0;
        o_entry.nibble   = 4'h0;
        o_entry.delay_us = D_CMD;
        case (i_idx)
            4'd0:    begin o_entry.nibble = 4'h3; o_entry.delay_us = 13'd4100;  end
            4'd1:    begin o_entry.nibble = 4'h3; o_entry.delay_us = 13'd100;   end
            4'd2:    begin o_entry.nibble = 4'h3; o_entry.delay_us = D_CMD;     end
            4'd3:    begin o_entry.nibble = 4'h2; o_entry.delay_us = D_CMD;     end
            4'd4:    begin o_entry.nibble = 4'h2; o_entry.delay_us = D_NIB;     end
            4'd5:    begin o_entry.nibble = 4'h8; o_entry.delay_us = D_CMD;     end
            4'd6:    begin o_entry.nibble = 4'h0; o_entry.delay_us = D_NIB;     end
            4'd7:    begin o_entry.nibble = 4'h8; o_entry.delay_us = D_CMD;     end
            4'd8:    begin o_entry.nibble = 4'h0; o_entry.delay_us = D_NIB;     end
            4'd9:    begin o_entry.nibble = 4'h1; o_entry.delay_us = D_CLEAR;   end
            4'd10:   begin o_entry.nibble = 4'h0; o_entry.delay_us = D_NIB;     end
            4'd11:   begin o_entry.nibble = 4'h6; o_entry.delay_us = D_CMD;     end
            4'd12:   begin o_entry.nibble = 4'h0; o_entry.delay_us = D_NIB;     end
            4'd13:   begin o_entry.nibble = 4'hC; o_entry.delay_us = D_CMD;     end
            default: begin o_entry.nibble = 4'h0; o_entry.delay_us = D_CMD;     end
        endcase
    end
endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 sequencer in front of a 4-bit nibble-transfer block.
// After reset it waits POWERUP_US, plays the 14-transfer init sequence, then
// accepts host bytes and sends each as a high and a low nibble.
// Ports:
//   CLK, RST_N   : clock, asynchronous active-low reset
//   wr           : host byte channel (lcd_ctrl_if.slave)
//   init_done    : high from the end of init until reset
//   sendCommand  : one-cycle start pulse to the transfer block
//   command      : {rs, nibble}, held until commandDone
//   commandDelay : post-transfer settle time in CLK cycles, held until commandDone
//   commandDone  : one-cycle completion pulse from the transfer block
//   o_state      : current sequencer state (debug)
// Build option: LCD_CTRL_LINE_WRAP_EN adds 16x2 column tracking and an automatic
// set-DDRAM address write whenever a character wraps the column 15 -> 0.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned FREQ       = 50000000,
    parameter int unsigned POWERUP_US = 15000,
    parameter int unsigned CMD_US     = 40,
    parameter int unsigned CLEAR_US   = 1640,
    parameter int unsigned NIB_US     = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    lcd_ctrl_if.slave   wr,
    output logic        init_done,
    output logic        sendCommand,
    output logic [4:0]  command,
    output logic [20:0] commandDelay,
    input  logic        commandDone,
    output state_t      o_state
);
    localparam longint unsigned T1US      = us_to_cycles(64'd1, 64'(FREQ));
    localparam longint unsigned PWR_CYC   = us_to_cycles(64'(POWERUP_US), 64'(FREQ));
    localparam longint unsigned CMD_CYC   = us_to_cycles(64'(CMD_US), 64'(FREQ));
    localparam longint unsigned CLEAR_CYC = us_to_cycles(64'(CLEAR_US), 64'(FREQ));
    localparam longint unsigned NIB_CYC   = us_to_cycles(64'(NIB_US), 64'(FREQ));
    localparam longint unsigned LONG_CYC  = us_to_cycles(64'd4100, 64'(FREQ));

    localparam logic [23:0] PWR_LAST = 24'(PWR_CYC - 64'd1);
    localparam logic [20:0] C_CMD    = 21'(CMD_CYC);
    localparam logic [20:0] C_CLEAR  = 21'(CLEAR_CYC);
    localparam logic [20:0] C_NIB    = 21'(NIB_CYC);

    if (CMD_CYC > DELAY_MAX || CLEAR_CYC > DELAY_MAX || NIB_CYC > DELAY_MAX ||
        LONG_CYC > DELAY_MAX) begin : g_delay_overflow
        $fatal(1, "lcd_ctrl: a transfer delay does not fit the 21-bit commandDelay");
    end
    // The transfer block has no reset, so the power-up wait must outlast any
    // transfer that was in flight when RST_N was asserted.
    if (PWR_CYC > 64'hFFFFFF || PWR_CYC <= LONG_CYC || PWR_CYC <= CLEAR_CYC) begin : g_powerup_bad
        $fatal(1, "lcd_ctrl: POWERUP_US must fit 24 bits and exceed the longest delay");
    end

    state_t      r_state, w_nxt_state;
    logic [23:0] r_pwr_cnt, w_nxt_pwr_cnt;
    logic [3:0]  r_idx, w_nxt_idx;
    logic        r_init_done, w_nxt_init_done;
    logic        r_rs, w_nxt_rs;
    logic [3:0]  r_lo_nib, w_nxt_lo_nib;
    logic        r_lo_pend, w_nxt_lo_pend;
    logic        r_lo_clear, w_nxt_lo_clear;
    logic [4:0]  r_cmd, w_nxt_cmd;
    logic [20:0] r_delay, w_nxt_delay;
`ifdef LCD_CTRL_LINE_WRAP_EN
    logic [3:0]  r_col, w_nxt_col;
    logic        r_line, w_nxt_line;
    logic        r_wrap_pend, w_nxt_wrap_pend;
`endif

    logic [3:0]  w_rom_idx;
    init_entry_t w_entry;
    logic [20:0] w_rom_cycles;

    // The ROM is addressed with the entry that will be loaded next: entry 0
    // when leaving the power-up wait, otherwise the one after the current index.
    assign w_rom_idx    = (r_state == PWR_WAIT) ? 4'd0 : r_idx + 4'd1;
    assign w_rom_cycles = 21'(64'(w_entry.delay_us) * T1US);

    lcd_init_rom #(
        .CMD_US   (CMD_US),
        .CLEAR_US (CLEAR_US),
        .NIB_US   (NIB_US)
    ) u_rom (
        .i_idx   (w_rom_idx),
        .o_entry (w_entry)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= PWR_WAIT;
            r_pwr_cnt   <= '0;
            r_idx       <= '0;
            r_init_done <= 1'b0;
            r_rs        <= 1'b0;
            r_lo_nib    <= '0;
            r_lo_pend   <= 1'b0;
            r_lo_clear  <= 1'b0;
            r_cmd       <= '0;
            r_delay     <= '0;
`ifdef LCD_CTRL_LINE_WRAP_EN
            r_col       <= '0;
            r_line      <= 1'b0;
            r_wrap_pend <= 1'b0;
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_pwr_cnt   <= w_nxt_pwr_cnt;
            r_idx       <= w_nxt_idx;
            r_init_done <= w_nxt_init_done;
            r_rs        <= w_nxt_rs;
            r_lo_nib    <= w_nxt_lo_nib;
            r_lo_pend   <= w_nxt_lo_pend;
            r_lo_clear  <= w_nxt_lo_clear;
            r_cmd       <= w_nxt_cmd;
            r_delay     <= w_nxt_delay;
`ifdef LCD_CTRL_LINE_WRAP_EN
            r_col       <= w_nxt_col;
            r_line      <= w_nxt_line;
            r_wrap_pend <= w_nxt_wrap_pend;
`endif
        end
    end

    // command/commandDelay are loaded on every transition into ISSUE and are
    // otherwise left alone, which keeps them stable until commandDone.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_pwr_cnt   = r_pwr_cnt;
        w_nxt_idx       = r_idx;
        w_nxt_init_done = r_init_done;
        w_nxt_rs        = r_rs;
        w_nxt_lo_nib    = r_lo_nib;
        w_nxt_lo_pend   = r_lo_pend;
        w_nxt_lo_clear  = r_lo_clear;
        w_nxt_cmd       = r_cmd;
        w_nxt_delay     = r_delay;
`ifdef LCD_CTRL_LINE_WRAP_EN
        w_nxt_col       = r_col;
        w_nxt_line      = r_line;
        w_nxt_wrap_pend = r_wrap_pend;
`endif
        case (r_state)
            PWR_WAIT: begin
                if (r_pwr_cnt == PWR_LAST) begin
                    w_nxt_state = ISSUE;
                    w_nxt_idx   = 4'd0;
                    w_nxt_cmd   = {w_entry.rs, w_entry.nibble};
                    w_nxt_delay = w_rom_cycles;
                end else begin
                    w_nxt_pwr_cnt = r_pwr_cnt + 24'd1;
                end
            end
            ISSUE: w_nxt_state = WAIT;
            WAIT: begin
                if (commandDone) w_nxt_state = GAP;
            end
            GAP: begin
                if (r_lo_pend) begin
                    w_nxt_state   = ISSUE;
                    w_nxt_lo_pend = 1'b0;
                    w_nxt_cmd     = {r_rs, r_lo_nib};
                    w_nxt_delay   = r_lo_clear ? C_CLEAR : C_CMD;
                end
`ifdef LCD_CTRL_LINE_WRAP_EN
                else if (r_wrap_pend) begin
                    // Set-DDRAM to the start of the other line: 0xC0 or 0x80.
                    w_nxt_state     = ISSUE;
                    w_nxt_wrap_pend = 1'b0;
                    w_nxt_line      = ~r_line;
                    w_nxt_rs        = 1'b0;
                    w_nxt_lo_nib    = 4'h0;
                    w_nxt_lo_pend   = 1'b1;
                    w_nxt_lo_clear  = 1'b0;
                    w_nxt_cmd       = {1'b0, (r_line ? 4'h8 : 4'hC)};
                    w_nxt_delay     = C_CMD;
                end
`endif
                else if (r_init_done) begin
                    w_nxt_state = READY;
                end else if (r_idx == 4'(INIT_LEN - 1)) begin
                    w_nxt_state     = READY;
                    w_nxt_init_done = 1'b1;
                end else begin
                    w_nxt_state = ISSUE;
                    w_nxt_idx   = r_idx + 4'd1;
                    w_nxt_cmd   = {w_entry.rs, w_entry.nibble};
                    w_nxt_delay = w_rom_cycles;
                end
            end
            READY: begin
                if (wr.wr_valid) begin
                    w_nxt_state    = ISSUE;
                    w_nxt_rs       = wr.wr_rs;
                    w_nxt_lo_nib   = wr.wr_data[3:0];
                    w_nxt_lo_pend  = 1'b1;
                    // Clear and home need the long settle after their low nibble.
                    w_nxt_lo_clear = !wr.wr_rs && (wr.wr_data inside {8'h01, 8'h02, 8'h03});
                    w_nxt_cmd      = {wr.wr_rs, wr.wr_data[7:4]};
                    w_nxt_delay    = C_NIB;
`ifdef LCD_CTRL_LINE_WRAP_EN
                    if (wr.wr_rs) begin
                        w_nxt_col = r_col + 4'd1;
                        if (r_col == 4'hF) w_nxt_wrap_pend = 1'b1;
                    end else if (wr.wr_data == 8'h01 || wr.wr_data == 8'h02) begin
                        w_nxt_col  = 4'd0;
                        w_nxt_line = 1'b0;
                    end
`endif
                end
            end
            default: w_nxt_state = PWR_WAIT;
        endcase
    end

    assign wr.wr_ready   = (r_state == READY);
    assign sendCommand   = (r_state == ISSUE);
    assign command       = r_cmd;
    assign commandDelay  = r_delay;
    assign init_done     = r_init_done;
    assign o_state       = r_state;

endmodule
